sfm_acc_ctrl_mc: RTL and testbench
==================================

SFM_ACC_CTRL_MC -- requirements
Module: sfm_acc_ctrl_mc

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of accumulation channels sharing one FMA, valid range 1..16.
REQ-002 SHALL have parameter FMA_REGS, default 3: FMA pipeline depth, equal to the partial sums in flight per channel, minimum 1.
REQ-003 SHALL have parameter MAX_INV_ITERS, default 3: maximum Newton-Raphson iterations.
REQ-004 SHALL have parameter COMB_INV, default 0: 1 means the reciprocal first approximation is combinational.
REQ-005 SHALL have ports, in this order:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous clear.
- addend_valid_i  in  1  datapath holds a valid addend.
- acc_finished_i  in  1  last addend issued.
- acc_only_i  in  1  skip inversion.
- load_reciprocal_i  in  1  externally loaded reciprocal.
- n_iters_i  in  IW=$clog2(MAX_INV_ITERS+1)  runtime iteration count.
- datapath_empty_i  in  1  addend/factor FIFOs empty.
- fma_o_valid_i  in  1  FMA result valid.
- inv_appr_valid_i  in  1  first approximation ready.
- ch_sel_o  out  max(1,$clog2(N_CH))  active channel.
- single-bit outputs: push_fma_res_o, disable_ready_o, reducing_o, inverting_o, inv_enable_o, den_enable_o, inv_fma_o, fma_inv_valid_o, first_inv_iter_o, new_inv_iter_o, acc_done_o (pulse per channel), inv_done_o (pulse per channel), res_valid_o, busy_o.

Function
REQ-006 SHALL use states IDLE, COMPUTING, FINISHING, REDUCTION, INVERSION, INV_FMA, INV_MUL and FINISHED; busy_o is 1 in every state except IDLE and FINISHED.
REQ-007 SHALL drive every output to 0 by default each cycle; each state asserts only the outputs listed for it.
REQ-008 In IDLE, SHALL go to COMPUTING on addend_valid_i, else to FINISHED on load_reciprocal_i; addend_valid_i wins if both are high.
REQ-009 In COMPUTING, SHALL on acc_finished_i go to FINISHING and latch iters_q = min(n_iters_i, MAX_INV_ITERS).
REQ-010 In FINISHING, when datapath_empty_i & ~addend_valid_i, SHALL go to REDUCTION and in that cycle:
- assert push_fma_res_o and reducing_o;
- load ch_q=0, inflight_q=FMA_REGS, parity_q=0.
REQ-011 In REDUCTION, SHALL assert reducing_o and disable_ready_o; on each fma_o_valid_i:
- if inflight_q==1 and parity_q==0: channel reduction complete (REQ-012);
- else if parity_q==0: assert push_fma_res_o and set parity_q=1;
- else: set parity_q=0 and decrement inflight_q.
REQ-012 On channel reduction complete, SHALL pulse acc_done_o and den_enable_o, then:
- if acc_only_i: advance to the next channel (REQ-016);
- else if COMB_INV: assert inverting_o and inv_enable_o and start inversion (REQ-014);
- else: assert inverting_o and inv_enable_o and go to INVERSION.
REQ-013 In INVERSION, SHALL assert inverting_o and start inversion (REQ-014) on inv_appr_valid_i.
REQ-014 Start inversion SHALL:
- if iters_q==0: pulse inv_done_o and advance to the next channel;
- else: go to INV_FMA, clear iter_cnt, assert fma_inv_valid_o, inv_fma_o and first_inv_iter_o.
REQ-015 Newton-Raphson loop, with inverting_o asserted in both states:
- INV_FMA, on fma_o_valid_i: go to INV_MUL and assert fma_inv_valid_o;
- INV_MUL, on fma_o_valid_i: assert new_inv_iter_o and increment iter_cnt;
- INV_MUL, if iter_cnt==iters_q-1: pulse inv_done_o and advance to the next channel;
- INV_MUL otherwise: go to INV_FMA and assert inv_fma_o and fma_inv_valid_o.
REQ-016 Channel advance SHALL:
- if ch_q==N_CH-1: go to IDLE when acc_only_i, else to FINISHED;
- otherwise: increment ch_q, reload inflight_q=FMA_REGS and parity_q=0, and go to REDUCTION.
REQ-017 ch_sel_o SHALL equal ch_q; ch_q SHALL never exceed N_CH-1.
REQ-018 In FINISHED, SHALL assert res_valid_o, and go to COMPUTING with ch_q=0 on addend_valid_i.
REQ-019 clear_i SHALL take priority over all transitions: next cycle in IDLE with ch_q, inflight_q, parity_q, iter_cnt and iters_q all 0.

Reset
REQ-020 On rst_ni low, SHALL asynchronously enter IDLE with all counters and outputs 0 (ch_sel_o=0); reset asserted mid-inversion SHALL abort with no inv_done_o pulse.

Verification
REQ-021 N_CH=1, FMA_REGS=4, acc_only_i=1: FINISHING exit, then 7 fma_o_valid_i pulses -> push_fma_res_o on pulses 1, 3 and 5, acc_done_o on pulse 7, then IDLE.
REQ-022 N_CH=2, FMA_REGS=1, COMB_INV=1, n_iters_i=2 -> per channel:
- acc_done_o and first_inv_iter_o on the same cycle;
- 4 FMA results, with new_inv_iter_o twice;
- inv_done_o on the 4th result;
- ch_sel_o 0 then 1, ending in FINISHED with res_valid_o=1.
REQ-023 n_iters_i=0, COMB_INV=0 -> inv_done_o on the inv_appr_valid_i cycle with no fma_inv_valid_o; n_iters_i=7 with MAX_INV_ITERS=3 -> exactly 3 new_inv_iter_o pulses.
REQ-024 IDLE with addend_valid_i and load_reciprocal_i both high -> COMPUTING; load_reciprocal_i alone -> FINISHED, res_valid_o=1 next cycle.
REQ-025 clear_i during INV_MUL of channel 1 -> IDLE next cycle with ch_sel_o=0; a fresh run then reduces channel 0 first.

Source files
------------

// File: rtl/sfm_acc_ctrl_mc.sv
// ---------------------------------------------------------------------------
// sfm_acc_ctrl_mc
// Control FSM for a multi-channel accumulator that shares one pipelined FMA
// between N_CH channels, followed by an optional Newton-Raphson reciprocal
// of each channel's sum.
//
// A run goes through these steps:
//   - Accumulate addends.
//   - Drain the datapath.
//   - Reduce each channel's FMA_REGS in-flight partial sums down to one value.
//   - Unless acc_only_i is set, refine a reciprocal of that value through
//     FMA/MUL iteration pairs.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous clear back to IDLE
//   addend_valid_i         datapath holds a valid addend
//   acc_finished_i         last addend has been issued
//   acc_only_i             skip the reciprocal stage
//   load_reciprocal_i      reciprocal loaded externally, go straight to FINISHED
//   n_iters_i              requested Newton-Raphson iterations (clamped)
//   datapath_empty_i       addend/factor FIFOs are empty
//   fma_o_valid_i          FMA result valid
//   inv_appr_valid_i       reciprocal first approximation ready
//   ch_sel_o               channel currently reduced/inverted
//   remaining outputs      single-cycle datapath controls and status flags
// ---------------------------------------------------------------------------
module sfm_acc_ctrl_mc #(
   parameter int unsigned N_CH          = 2,
   parameter int unsigned FMA_REGS      = 3,
   parameter int unsigned MAX_INV_ITERS = 3,
   parameter int unsigned COMB_INV      = 0,
   localparam int unsigned IW = (MAX_INV_ITERS > 0) ? $clog2(MAX_INV_ITERS + 1) : 1,
   localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          addend_valid_i,
   input  logic          acc_finished_i,
   input  logic          acc_only_i,
   input  logic          load_reciprocal_i,
   input  logic [IW-1:0] n_iters_i,
   input  logic          datapath_empty_i,
   input  logic          fma_o_valid_i,
   input  logic          inv_appr_valid_i,
   output logic [CW-1:0] ch_sel_o,
   output logic          push_fma_res_o,
   output logic          disable_ready_o,
   output logic          reducing_o,
   output logic          inverting_o,
   output logic          inv_enable_o,
   output logic          den_enable_o,
   output logic          inv_fma_o,
   output logic          fma_inv_valid_o,
   output logic          first_inv_iter_o,
   output logic          new_inv_iter_o,
   output logic          acc_done_o,
   output logic          inv_done_o,
   output logic          res_valid_o,
   output logic          busy_o
);

   localparam int unsigned RW = $clog2(FMA_REGS + 1);

   typedef enum logic [2:0] {
      IDLE, COMPUTING, FINISHING, REDUCTION, INVERSION, INV_FMA, INV_MUL, FINISHED
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] ch_q, ch_d;
   logic [RW-1:0] inflight_q, inflight_d;
   logic          parity_q, parity_d;
   logic [IW-1:0] iter_cnt_q, iter_cnt_d;
   logic [IW-1:0] iters_q, iters_d;
   logic          start_inv;
   logic          advance;

   // State and counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         ch_q       <= '0;
         inflight_q <= '0;
         parity_q   <= 1'b0;
         iter_cnt_q <= '0;
         iters_q    <= '0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         inflight_q <= inflight_d;
         parity_q   <= parity_d;
         iter_cnt_q <= iter_cnt_d;
         iters_q    <= iters_d;
      end
   end

   // Next-state and output logic.
   // start_inv and advance are shared actions requested from several states.
   // They are resolved after the case statement, so every path that starts
   // an inversion or moves to the next channel behaves identically.
   always_comb begin
      state_d          = state_q;
      ch_d             = ch_q;
      inflight_d       = inflight_q;
      parity_d         = parity_q;
      iter_cnt_d       = iter_cnt_q;
      iters_d          = iters_q;
      push_fma_res_o   = 1'b0;
      disable_ready_o  = 1'b0;
      reducing_o       = 1'b0;
      inverting_o      = 1'b0;
      inv_enable_o     = 1'b0;
      den_enable_o     = 1'b0;
      inv_fma_o        = 1'b0;
      fma_inv_valid_o  = 1'b0;
      first_inv_iter_o = 1'b0;
      new_inv_iter_o   = 1'b0;
      acc_done_o       = 1'b0;
      inv_done_o       = 1'b0;
      res_valid_o      = 1'b0;
      start_inv        = 1'b0;
      advance          = 1'b0;
      busy_o           = (state_q != IDLE) && (state_q != FINISHED);

      if (clear_i) begin
         state_d    = IDLE;
         ch_d       = '0;
         inflight_d = '0;
         parity_d   = 1'b0;
         iter_cnt_d = '0;
         iters_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (addend_valid_i) begin
                  state_d = COMPUTING;
               end else if (load_reciprocal_i) begin
                  state_d = FINISHED;
               end
            end
            COMPUTING: begin
               if (acc_finished_i) begin
                  state_d = FINISHING;
                  iters_d = (n_iters_i > IW'(MAX_INV_ITERS)) ? IW'(MAX_INV_ITERS) : n_iters_i;
               end
            end
            FINISHING: begin
               if (datapath_empty_i && !addend_valid_i) begin
                  push_fma_res_o = 1'b1;
                  reducing_o     = 1'b1;
                  state_d        = REDUCTION;
                  ch_d           = '0;
                  inflight_d     = RW'(FMA_REGS);
                  parity_d       = 1'b0;
               end
            end
            // Partial sums are combined pairwise.
            // The first result of each pair is pushed back into the FMA.
            // The second result retires one in-flight slot.
            // The last remaining slot with parity 0 holds the final sum.
            REDUCTION: begin
               reducing_o      = 1'b1;
               disable_ready_o = 1'b1;
               if (fma_o_valid_i) begin
                  if (inflight_q == RW'(1) && !parity_q) begin
                     acc_done_o   = 1'b1;
                     den_enable_o = 1'b1;
                     if (acc_only_i) begin
                        advance = 1'b1;
                     end else begin
                        inverting_o  = 1'b1;
                        inv_enable_o = 1'b1;
                        if (COMB_INV != 0) begin
                           start_inv = 1'b1;
                        end else begin
                           state_d = INVERSION;
                        end
                     end
                  end else if (!parity_q) begin
                     push_fma_res_o = 1'b1;
                     parity_d       = 1'b1;
                  end else begin
                     parity_d   = 1'b0;
                     inflight_d = inflight_q - RW'(1);
                  end
               end
            end
            INVERSION: begin
               inverting_o = 1'b1;
               if (inv_appr_valid_i) begin
                  start_inv = 1'b1;
               end
            end
            INV_FMA: begin
               inverting_o = 1'b1;
               if (fma_o_valid_i) begin
                  state_d         = INV_MUL;
                  fma_inv_valid_o = 1'b1;
               end
            end
            INV_MUL: begin
               inverting_o = 1'b1;
               if (fma_o_valid_i) begin
                  new_inv_iter_o = 1'b1;
                  iter_cnt_d     = iter_cnt_q + IW'(1);
                  if (iter_cnt_q + IW'(1) == iters_q) begin
                     inv_done_o = 1'b1;
                     advance    = 1'b1;
                  end else begin
                     state_d         = INV_FMA;
                     inv_fma_o       = 1'b1;
                     fma_inv_valid_o = 1'b1;
                  end
               end
            end
            FINISHED: begin
               res_valid_o = 1'b1;
               if (addend_valid_i) begin
                  state_d = COMPUTING;
                  ch_d    = '0;
               end
            end
            default: state_d = IDLE;
         endcase

         // A zero iteration count means the first approximation is already
         // the result, so the channel finishes immediately.
         if (start_inv) begin
            if (iters_q == '0) begin
               inv_done_o = 1'b1;
               advance    = 1'b1;
            end else begin
               state_d          = INV_FMA;
               iter_cnt_d       = '0;
               fma_inv_valid_o  = 1'b1;
               inv_fma_o        = 1'b1;
               first_inv_iter_o = 1'b1;
            end
         end

         if (advance) begin
            if (ch_q == CW'(N_CH - 1)) begin
               state_d = acc_only_i ? IDLE : FINISHED;
            end else begin
               ch_d       = ch_q + CW'(1);
               inflight_d = RW'(FMA_REGS);
               parity_d   = 1'b0;
               state_d    = REDUCTION;
            end
         end
      end
   end

   assign ch_sel_o = ch_q;

endmodule

// File: tb/tb_sfm_acc_ctrl_mc.sv
// ---------------------------------------------------------------------------
// tb_sfm_acc_ctrl_mc
// Two controllers share the same random inputs:
//   dut_a: N_CH=2, FMA_REGS=1, COMB_INV=1, MAX_INV_ITERS=3
//   dut_b: N_CH=3, FMA_REGS=4, COMB_INV=0, MAX_INV_ITERS=4
// Each controller is compared every cycle against a counting reference
// model. The reference model tracks:
//   - how many FMA results a channel has consumed, and
//   - how many reciprocal iterations have completed.
// Both models predict all output bits.
// ---------------------------------------------------------------------------
module tb_sfm_acc_ctrl_mc;

   localparam int B_BUSY = 0, B_RV = 1, B_INVD = 2, B_ACCD = 3, B_NEW = 4;
   localparam int B_FIRST = 5, B_FIV = 6, B_IFMA = 7, B_DEN = 8, B_INVEN = 9;
   localparam int B_INV = 10, B_RED = 11, B_DIS = 12, B_PUSH = 13;
   localparam int P_IDLE = 0, P_ACC = 1, P_DRAIN = 2, P_RED = 3, P_APPR = 4, P_NR = 5, P_DONE = 6;

   typedef struct {
      int ph;
      int ch;
      int cnt;
      int iters;
   } model_t;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       clear_i, addend_valid_i, acc_finished_i, acc_only_i, load_reciprocal_i;
   logic [2:0] n_iters;
   logic       datapath_empty_i, fma_o_valid_i, inv_appr_valid_i;
   wire [15:0] obs_a;
   wire [15:0] obs_b;

   model_t      ma, mb;
   logic [15:0] exp_a, exp_b;
   int          tests = 0;
   int          fails = 0;
   int          cycle = 0;

   always #5 clk_i = ~clk_i;

   assign obs_a[15] = 1'b0;

   sfm_acc_ctrl_mc #(.N_CH(2), .FMA_REGS(1), .MAX_INV_ITERS(3), .COMB_INV(1)) dut_a (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
      .addend_valid_i(addend_valid_i), .acc_finished_i(acc_finished_i),
      .acc_only_i(acc_only_i), .load_reciprocal_i(load_reciprocal_i),
      .n_iters_i(n_iters[1:0]), .datapath_empty_i(datapath_empty_i),
      .fma_o_valid_i(fma_o_valid_i), .inv_appr_valid_i(inv_appr_valid_i),
      .ch_sel_o(obs_a[14]), .push_fma_res_o(obs_a[B_PUSH]),
      .disable_ready_o(obs_a[B_DIS]), .reducing_o(obs_a[B_RED]),
      .inverting_o(obs_a[B_INV]), .inv_enable_o(obs_a[B_INVEN]),
      .den_enable_o(obs_a[B_DEN]), .inv_fma_o(obs_a[B_IFMA]),
      .fma_inv_valid_o(obs_a[B_FIV]), .first_inv_iter_o(obs_a[B_FIRST]),
      .new_inv_iter_o(obs_a[B_NEW]), .acc_done_o(obs_a[B_ACCD]),
      .inv_done_o(obs_a[B_INVD]), .res_valid_o(obs_a[B_RV]), .busy_o(obs_a[B_BUSY])
   );

   sfm_acc_ctrl_mc #(.N_CH(3), .FMA_REGS(4), .MAX_INV_ITERS(4), .COMB_INV(0)) dut_b (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
      .addend_valid_i(addend_valid_i), .acc_finished_i(acc_finished_i),
      .acc_only_i(acc_only_i), .load_reciprocal_i(load_reciprocal_i),
      .n_iters_i(n_iters), .datapath_empty_i(datapath_empty_i),
      .fma_o_valid_i(fma_o_valid_i), .inv_appr_valid_i(inv_appr_valid_i),
      .ch_sel_o(obs_b[15:14]), .push_fma_res_o(obs_b[B_PUSH]),
      .disable_ready_o(obs_b[B_DIS]), .reducing_o(obs_b[B_RED]),
      .inverting_o(obs_b[B_INV]), .inv_enable_o(obs_b[B_INVEN]),
      .den_enable_o(obs_b[B_DEN]), .inv_fma_o(obs_b[B_IFMA]),
      .fma_inv_valid_o(obs_b[B_FIV]), .first_inv_iter_o(obs_b[B_FIRST]),
      .new_inv_iter_o(obs_b[B_NEW]), .acc_done_o(obs_b[B_ACCD]),
      .inv_done_o(obs_b[B_INVD]), .res_valid_o(obs_b[B_RV]), .busy_o(obs_b[B_BUSY])
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      tests++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic chance(input int pct);
      return $urandom_range(0, 99) < pct;
   endfunction

   // Random control inputs, with rare clears so that runs usually complete.
   task automatic applyStimulus();
      clear_i           = chance(1);
      addend_valid_i    = chance(25);
      acc_finished_i    = chance(30);
      acc_only_i        = chance(50);
      load_reciprocal_i = chance(20);
      n_iters           = 3'($urandom_range(0, 7));
      datapath_empty_i  = chance(75);
      fma_o_valid_i     = chance(55);
      inv_appr_valid_i  = chance(40);
   endtask

   // Reference behaviour for one cycle.
   // A channel reduction consumes 2*f-1 FMA results:
   //   - results 1,3,..,2f-3 are pushed back;
   //   - the last result is the channel sum.
   // Each reciprocal iteration consumes two results (FMA then MUL).
   task automatic modelStep(inout model_t m, input int nch, input int f, input int comb,
                            input int maxit, input int nval, output logic [15:0] e);
      bit next_ch;
      bit begin_nr;
      e        = '0;
      next_ch  = 1'b0;
      begin_nr = 1'b0;
      e[15:14] = 2'(m.ch);
      e[B_BUSY] = (m.ph != P_IDLE) && (m.ph != P_DONE);
      if (clear_i) begin
         m = '{P_IDLE, 0, 0, 0};
         return;
      end
      case (m.ph)
         P_IDLE: begin
            if (addend_valid_i) m.ph = P_ACC;
            else if (load_reciprocal_i) m.ph = P_DONE;
         end
         P_ACC: begin
            if (acc_finished_i) begin
               m.ph    = P_DRAIN;
               m.iters = (nval > maxit) ? maxit : nval;
            end
         end
         P_DRAIN: begin
            if (datapath_empty_i && !addend_valid_i) begin
               e[B_PUSH] = 1'b1;
               e[B_RED]  = 1'b1;
               m.ph  = P_RED;
               m.ch  = 0;
               m.cnt = 0;
            end
         end
         P_RED: begin
            e[B_RED] = 1'b1;
            e[B_DIS] = 1'b1;
            if (fma_o_valid_i) begin
               if (m.cnt == 2 * f - 2) begin
                  e[B_ACCD] = 1'b1;
                  e[B_DEN]  = 1'b1;
                  if (acc_only_i) next_ch = 1'b1;
                  else begin
                     e[B_INV]   = 1'b1;
                     e[B_INVEN] = 1'b1;
                     if (comb != 0) begin_nr = 1'b1;
                     else m.ph = P_APPR;
                  end
               end else begin
                  if (m.cnt % 2 == 0) e[B_PUSH] = 1'b1;
                  m.cnt++;
               end
            end
         end
         P_APPR: begin
            e[B_INV] = 1'b1;
            if (inv_appr_valid_i) begin_nr = 1'b1;
         end
         P_NR: begin
            e[B_INV] = 1'b1;
            if (fma_o_valid_i) begin
               if (m.cnt % 2 == 0) e[B_FIV] = 1'b1;
               else begin
                  e[B_NEW] = 1'b1;
                  if ((m.cnt + 1) / 2 == m.iters) begin
                     e[B_INVD] = 1'b1;
                     next_ch   = 1'b1;
                  end else begin
                     e[B_IFMA] = 1'b1;
                     e[B_FIV]  = 1'b1;
                  end
               end
               m.cnt++;
            end
         end
         P_DONE: begin
            e[B_RV] = 1'b1;
            if (addend_valid_i) begin
               m.ph = P_ACC;
               m.ch = 0;
            end
         end
         default: m.ph = P_IDLE;
      endcase
      if (begin_nr) begin
         if (m.iters == 0) begin
            e[B_INVD] = 1'b1;
            next_ch   = 1'b1;
         end else begin
            m.ph       = P_NR;
            m.cnt      = 0;
            e[B_FIV]   = 1'b1;
            e[B_IFMA]  = 1'b1;
            e[B_FIRST] = 1'b1;
         end
      end
      if (next_ch) begin
         if (m.ch == nch - 1) m.ph = acc_only_i ? P_IDLE : P_DONE;
         else begin
            m.ch++;
            m.cnt = 0;
            m.ph  = P_RED;
         end
      end
   endtask

   // Drive, settle, predict, compare; the DUTs advance at the following posedge.
   task automatic cycleBody();
      applyStimulus();
      #1;
      modelStep(ma, 2, 1, 1, 3, int'(n_iters[1:0]), exp_a);
      modelStep(mb, 3, 4, 0, 4, int'(n_iters), exp_b);
      checkOutput($sformatf("dut_a@%0d", cycle), obs_a, exp_a);
      checkOutput($sformatf("dut_b@%0d", cycle), obs_b, exp_b);
      cycle++;
   endtask

   task automatic runCycle();
      @(negedge clk_i);
      cycleBody();
   endtask

   initial begin
      bit reached;
      rst_ni            = 1'b0;
      clear_i           = 1'b0;
      addend_valid_i    = 1'b0;
      acc_finished_i    = 1'b0;
      acc_only_i        = 1'b0;
      load_reciprocal_i = 1'b0;
      n_iters           = '0;
      datapath_empty_i  = 1'b0;
      fma_o_valid_i     = 1'b0;
      inv_appr_valid_i  = 1'b0;
      ma = '{P_IDLE, 0, 0, 0};
      mb = '{P_IDLE, 0, 0, 0};

      @(negedge clk_i);
      #2;
      checkOutput("reset_a", obs_a, 16'h0000);
      checkOutput("reset_b", obs_b, 16'h0000);
      @(negedge clk_i);
      rst_ni = 1'b1;
      cycleBody();

      // Run until dut_b is inside a reciprocal loop, then reset asynchronously.
      // Every output must drop at once, with no inv_done pulse.
      reached = 1'b0;
      for (int i = 0; i < 3000 && !reached; i++) begin
         runCycle();
         if (mb.ph == P_NR && i > 200) reached = 1'b1;
      end
      if (!reached) begin
         fails++;
         $display("[TB] FAIL nr_reach: got no inversion loop, expected one within 3000 cycles");
      end else begin
         #2 rst_ni = 1'b0;
         #1;
         checkOutput("async_rst_a", obs_a, 16'h0000);
         checkOutput("async_rst_b", obs_b, 16'h0000);
         ma = '{P_IDLE, 0, 0, 0};
         mb = '{P_IDLE, 0, 0, 0};
         @(negedge clk_i);
         rst_ni = 1'b1;
         cycleBody();
      end

      for (int i = 0; i < 4000; i++) runCycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
